// File: rtl/io_bus_pkg.sv
// Shared types and defaults for the MMIO bus decoder and its address matcher.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int          ERR_CNT_W     = 8;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
  localparam int          DEF_SPAN_LOG2 = 4;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/io_bus_decoder_if.sv
// CPU-side request/response bundle of the MMIO decoder.
interface io_bus_decoder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_cs;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;

  modport master (output cpu_cs, cpu_we, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_ready, cpu_err);
  modport slave  (input  cpu_cs, cpu_we, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_ready, cpu_err);
endinterface

// File: rtl/io_addr_match.sv
// Combinational window decode: byte address -> hit, word alignment, window index, offset.
module io_addr_match
  import io_bus_pkg::*;
#(
  parameter int                NUM_DEV   = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int                SPAN_LOG2 = DEF_SPAN_LOG2,
  localparam int               IDX_W     = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
  input  logic [ADDR_W-1:0]    addr,
  output logic                 hit,
  output logic                 aligned,
  output logic [IDX_W-1:0]     idx,
  output logic [SPAN_LOG2-1:0] off
);

  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-1:0] win;

  // Below-base addresses wrap to huge values in rel, so the explicit >= guard is what rejects them.
  always_comb begin
    rel     = addr - BASE_ADDR;
    win     = rel >> SPAN_LOG2;
    hit     = (addr >= BASE_ADDR) && (win < ADDR_W'(NUM_DEV));
    aligned = (addr[1:0] == 2'b00);
    idx     = win[IDX_W-1:0];
    off     = rel[SPAN_LOG2-1:0];
  end

endmodule

// File: rtl/io_bus_decoder.sv
// MMIO decoder/router: CPU data port to NUM_DEV equal windows, with wait states,
// timeout/misalignment errors and a saturating error counter.
module io_bus_decoder
  import io_bus_pkg::*;
#(
  parameter int                NUM_DEV   = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int                SPAN_LOG2 = DEF_SPAN_LOG2,
  parameter int                TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  io_bus_decoder_if.slave           cpu,
  output logic [NUM_DEV-1:0]        dev_cs,
  output logic                      dev_we,
  output logic [SPAN_LOG2-1:0]      dev_off,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]        dev_ack,
  output logic [ERR_CNT_W-1:0]      err_count
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 hit, aligned;
  logic [IDX_W-1:0]     idx, idx_q;
  logic [SPAN_LOG2-1:0] off;
  logic [TMR_W-1:0]     timer_q;
  logic                 sel_ack, timed_out, go_access;
  logic [DATA_W-1:0]    sel_rdata;

  io_addr_match #(
    .NUM_DEV  (NUM_DEV),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .SPAN_LOG2(SPAN_LOG2)
  ) u_match (
    .addr   (cpu.cpu_addr),
    .hit    (hit),
    .aligned(aligned),
    .idx    (idx),
    .off    (off)
  );

  // Only the latched device may complete the access; other acks are ignored.
  assign sel_ack   = dev_ack[idx_q];
  assign sel_rdata = dev_rdata[int'(idx_q)*DATA_W +: DATA_W];
  assign go_access = hit && aligned;
  // The last wait edge is the TIMEOUT-th ACCESS edge; an ack on that edge still wins.
  assign timed_out = !sel_ack && (timer_q == TMR_LAST);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu.cpu_cs) state_d = go_access ? ACCESS : RESP;
      ACCESS:  if (sel_ack || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_cs        <= '0;
      dev_we        <= 1'b0;
      dev_off       <= '0;
      dev_wdata     <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      cpu.cpu_ready <= 1'b0;
      cpu.cpu_err   <= 1'b0;
      cpu.cpu_rdata <= '0;
      err_count     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu.cpu_cs) begin
            dev_we    <= cpu.cpu_we;
            dev_off   <= off;
            dev_wdata <= cpu.cpu_wdata;
            idx_q     <= idx;
            timer_q   <= '0;
            if (go_access) begin
              dev_cs <= NUM_DEV'(1) << idx;
            end else begin
              cpu.cpu_ready <= 1'b1;
              cpu.cpu_err   <= 1'b1;
              cpu.cpu_rdata <= '0;
              err_count     <= sat_inc(err_count);
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            dev_cs        <= '0;
            cpu.cpu_ready <= 1'b1;
            cpu.cpu_err   <= 1'b0;
            cpu.cpu_rdata <= dev_we ? '0 : sel_rdata;
          end else if (timed_out) begin
            dev_cs        <= '0;
            cpu.cpu_ready <= 1'b1;
            cpu.cpu_err   <= 1'b1;
            cpu.cpu_rdata <= '0;
            err_count     <= sat_inc(err_count);
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          cpu.cpu_ready <= 1'b0;
          cpu.cpu_err   <= 1'b0;
          cpu.cpu_rdata <= '0;
        end
        default: begin
          dev_cs        <= '0;
          cpu.cpu_ready <= 1'b0;
          cpu.cpu_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
